dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_addr_check.sv | 30 +++
 rtl/dmem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter and its address checker.
package dmem_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StDone   = 2'd2
  } dmem_state_e;

  // Requester port identifiers.
  localparam logic PortP0 = 1'b0;  // CPU
  localparam logic PortP1 = 1'b1;  // loader / debug

  // Default data-segment geometry.
  localparam logic [31:0] DefaultBaseAddr = 32'h1001_0000;
  localparam int unsigned DefaultDepth    = 2048;
  localparam int unsigned DefaultAw       = 11;

endpackage

// File: rtl/dmem_addr_check.sv
// Byte address to DMEM word index translation with legality check.
// A legal address is word aligned, at or above BASE_ADDR and inside DEPTH words.
module dmem_addr_check
  import dmem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DefaultBaseAddr,
  parameter int unsigned DEPTH     = DefaultDepth,
  parameter int unsigned AW        = DefaultAw
) (
  input  logic [31:0]   addr,
  output logic [AW-1:0] idx,
  output logic          legal
);

  logic [31:0] w_offset;
  logic [31:0] w_idx_full;

  // Offset into the segment and the full-width word index derived from it.
  always_comb begin
    w_offset   = addr - BASE_ADDR;
    w_idx_full = w_offset >> 2;
  end

  // Only the low AW bits address DMEM; the full index decides legality.
  always_comb begin
    idx   = w_idx_full[AW-1:0];
    legal = (addr[1:0] == 2'b00) && (addr >= BASE_ADDR) && (w_idx_full < DEPTH);
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port combinational-read DMEM.
// Each access takes three cycles: grant (IDLE), DMEM strobe (ACCESS), ack (DONE).
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DefaultBaseAddr,
  parameter int unsigned DEPTH     = DefaultDepth,
  parameter int unsigned AW        = DefaultAw
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [31:0]   p0_addr,
  input  logic [31:0]   p0_wdata,
  output logic          p0_ack,
  output logic          p0_err,
  output logic [31:0]   p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [31:0]   p1_addr,
  input  logic [31:0]   p1_wdata,
  output logic          p1_ack,
  output logic          p1_err,
  output logic [31:0]   p1_rdata,
  output logic          dm_w,
  output logic          dm_r,
  output logic [AW-1:0] dm_addr,
  output logic [31:0]   dm_wdata,
  input  logic [31:0]   dm_rdata,
  output logic          busy
);

  dmem_state_e r_state;
  logic        r_last;   // port that won the previous grant
  logic        r_win;    // port being served
  logic        r_we;
  logic        r_legal;
  logic        r_dm_w;
  logic        r_dm_r;
  logic [AW-1:0] r_dm_addr;
  logic [31:0] r_dm_wdata;
  logic        r_p0_ack;
  logic        r_p0_err;
  logic [31:0] r_p0_rdata;
  logic        r_p1_ack;
  logic        r_p1_err;
  logic [31:0] r_p1_rdata;

  logic          w_win;
  logic          w_we;
  logic [31:0]   w_addr;
  logic [31:0]   w_wdata;
  logic [AW-1:0] w_idx;
  logic          w_legal;

  // Round-robin pick: on a tie the port that did not win last time is served.
  always_comb begin
    w_win = PortP0;
    if (p0_req && p1_req) begin
      w_win = ~r_last;
    end else if (p1_req) begin
      w_win = PortP1;
    end
    w_we    = (w_win == PortP1) ? p1_we    : p0_we;
    w_addr  = (w_win == PortP1) ? p1_addr  : p0_addr;
    w_wdata = (w_win == PortP1) ? p1_wdata : p0_wdata;
  end

  dmem_addr_check #(
    .BASE_ADDR (BASE_ADDR),
    .DEPTH     (DEPTH),
    .AW        (AW)
  ) u_addr_check (
    .addr  (w_addr),
    .idx   (w_idx),
    .legal (w_legal)
  );

  // Arbiter FSM with all outputs registered; the check result is taken at grant time.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= StIdle;
      r_last     <= PortP1;
      r_win      <= PortP0;
      r_we       <= 1'b0;
      r_legal    <= 1'b0;
      r_dm_w     <= 1'b0;
      r_dm_r     <= 1'b0;
      r_dm_addr  <= '0;
      r_dm_wdata <= '0;
      r_p0_ack   <= 1'b0;
      r_p0_err   <= 1'b0;
      r_p0_rdata <= '0;
      r_p1_ack   <= 1'b0;
      r_p1_err   <= 1'b0;
      r_p1_rdata <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (p0_req || p1_req) begin
            r_state    <= StAccess;
            r_win      <= w_win;
            r_last     <= w_win;
            r_we       <= w_we;
            r_legal    <= w_legal;
            // Illegal accesses never touch DMEM.
            r_dm_w     <= w_legal & w_we;
            r_dm_r     <= w_legal & ~w_we;
            r_dm_addr  <= w_legal ? w_idx : '0;
            r_dm_wdata <= w_legal ? w_wdata : '0;
          end
        end
        StAccess: begin
          r_state    <= StDone;
          r_dm_w     <= 1'b0;
          r_dm_r     <= 1'b0;
          r_dm_addr  <= '0;
          r_dm_wdata <= '0;
          // Read data is captured only for legal reads, so writes/errors keep rdata.
          if (r_legal && !r_we) begin
            if (r_win == PortP1) begin
              r_p1_rdata <= dm_rdata;
            end else begin
              r_p0_rdata <= dm_rdata;
            end
          end
          r_p0_ack <= (r_win == PortP0);
          r_p0_err <= (r_win == PortP0) & ~r_legal;
          r_p1_ack <= (r_win == PortP1);
          r_p1_err <= (r_win == PortP1) & ~r_legal;
        end
        StDone: begin
          r_state  <= StIdle;
          r_p0_ack <= 1'b0;
          r_p0_err <= 1'b0;
          r_p1_ack <= 1'b0;
          r_p1_err <= 1'b0;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  // Output wiring.
  always_comb begin
    busy     = (r_state != StIdle);
    dm_w     = r_dm_w;
    dm_r     = r_dm_r;
    dm_addr  = r_dm_addr;
    dm_wdata = r_dm_wdata;
    p0_ack   = r_p0_ack;
    p0_err   = r_p0_err;
    p0_rdata = r_p0_rdata;
    p1_ack   = r_p1_ack;
    p1_err   = r_p1_err;
    p1_rdata = r_p1_rdata;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: transaction-level model plus directed scenarios.
module tb_dmem_arbiter;

  localparam logic [31:0] Base  = 32'h1001_0000;
  localparam int unsigned Depth = 2048;
  localparam int unsigned Aw    = 11;

  logic          clk = 1'b0;
  logic          rst;
  logic          p0_req, p0_we, p1_req, p1_we;
  logic [31:0]   p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic          p0_ack, p0_err, p1_ack, p1_err;
  logic [31:0]   p0_rdata, p1_rdata;
  logic          dm_w, dm_r, busy;
  logic [Aw-1:0] dm_addr;
  logic [31:0]   dm_wdata, dm_rdata;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .BASE_ADDR (Base),
    .DEPTH     (Depth),
    .AW        (Aw)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .p0_req   (p0_req),
    .p0_we    (p0_we),
    .p0_addr  (p0_addr),
    .p0_wdata (p0_wdata),
    .p0_ack   (p0_ack),
    .p0_err   (p0_err),
    .p0_rdata (p0_rdata),
    .p1_req   (p1_req),
    .p1_we    (p1_we),
    .p1_addr  (p1_addr),
    .p1_wdata (p1_wdata),
    .p1_ack   (p1_ack),
    .p1_err   (p1_err),
    .p1_rdata (p1_rdata),
    .dm_w     (dm_w),
    .dm_r     (dm_r),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_rdata (dm_rdata),
    .busy     (busy)
  );

  function automatic logic [31:0] pattern(input int unsigned i);
    return 32'hA000_0000 + i;
  endfunction

  // DMEM environment: combinational read, synchronous write, preloaded with a pattern.
  logic [31:0] dmem [Depth];
  logic        mem_init = 1'b0;
  assign dm_rdata = dmem[dm_addr];
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < Depth; i++) dmem[i] <= pattern(i);
      mem_init <= 1'b1;
    end else if (dm_w) begin
      dmem[dm_addr] <= dm_wdata;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Transaction model: a grant in cycle g means strobe in g+1, ack in g+2, idle again at g+3.
  int unsigned cyc = 0;
  int unsigned m_grant = 0;
  int unsigned m_idx = 0;
  logic        m_valid = 1'b0;
  logic        m_active = 1'b0;
  logic        m_last = 1'b1;
  logic        m_win = 1'b0;
  logic        m_we = 1'b0;
  logic        m_legal = 1'b0;
  logic [31:0] m_wdata = '0;
  logic [31:0] m_rdata [2];
  logic [31:0] ref_mem [Depth];

  always @(posedge clk) begin
    logic [31:0] a;
    if (!rst) begin
      if (!m_valid) begin
        for (int i = 0; i < Depth; i++) ref_mem[i] = pattern(i);
      end
      m_valid    = 1'b1;
      m_active   = 1'b0;
      m_last     = 1'b1;
      m_rdata[0] = '0;
      m_rdata[1] = '0;
    end else if (m_valid) begin
      if (m_active && cyc == m_grant + 1 && m_legal && !m_we) m_rdata[m_win] = ref_mem[m_idx];
      if ((!m_active || cyc >= m_grant + 3) && (p0_req || p1_req)) begin
        m_win    = (p0_req && p1_req) ? ~m_last : p1_req;
        m_last   = m_win;
        m_active = 1'b1;
        m_grant  = cyc;
        a        = m_win ? p1_addr : p0_addr;
        m_we     = m_win ? p1_we : p0_we;
        m_wdata  = m_win ? p1_wdata : p0_wdata;
        m_legal  = (a % 4 == 0) && (a >= Base) && ((a - Base) / 4 < Depth);
        m_idx    = (a - Base) / 4;
        if (m_legal && m_we) ref_mem[m_idx] = m_wdata;
      end
    end
    cyc++;
  end

  // Compare every output against the model on the falling edge.
  always @(negedge clk) begin
    logic strobe, ack;
    if (m_valid) begin
      strobe = m_active && (cyc == m_grant + 1);
      ack    = m_active && (cyc == m_grant + 2);
      check("busy", 32'(busy), 32'(strobe || ack));
      check("dm_w", 32'(dm_w), 32'(strobe && m_legal && m_we));
      check("dm_r", 32'(dm_r), 32'(strobe && m_legal && !m_we));
      if (!(strobe && !m_legal)) begin
        check("dm_addr", 32'(dm_addr), strobe ? (m_idx % Depth) : 0);
        check("dm_wdata", dm_wdata, strobe ? m_wdata : 32'h0);
      end
      check("p0_ack", 32'(p0_ack), 32'(ack && !m_win));
      check("p0_err", 32'(p0_err), 32'(ack && !m_win && !m_legal));
      check("p1_ack", 32'(p1_ack), 32'(ack && m_win));
      check("p1_err", 32'(p1_err), 32'(ack && m_win && !m_legal));
      check("p0_rdata", p0_rdata, m_rdata[0]);
      check("p1_rdata", p1_rdata, m_rdata[1]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] bad_addr [3];

  initial begin
    rst = 1'b0;
    p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
    bad_addr[0] = 32'h1001_2000;
    bad_addr[1] = 32'h1001_0002;
    bad_addr[2] = 32'h1000_FFFC;
    tick();
    tick();
    check("reset busy", 32'(busy), 32'h0);
    check("reset p0_rdata", p0_rdata, 32'h0);
    rst = 1'b1;
    tick();

    // Tie: p0 wins first (pointer resets to p1), then p1.
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = Base + 32'd20;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = Base + 32'd28;
    tick();
    check("tie1 dm_r", 32'(dm_r), 32'h1);
    check("tie1 dm_addr", 32'(dm_addr), 32'd5);
    tick();
    check("tie1 p0_ack", 32'(p0_ack), 32'h1);
    check("tie1 p1_ack", 32'(p1_ack), 32'h0);
    check("tie1 p0_rdata", p0_rdata, 32'hA000_0005);
    check("tie1 busy", 32'(busy), 32'h1);
    tick();
    tick();
    check("tie2 dm_addr", 32'(dm_addr), 32'd7);
    tick();
    check("tie2 p1_ack", 32'(p1_ack), 32'h1);
    check("tie2 p1_rdata", p1_rdata, 32'hA000_0007);
    p0_req = 1'b0; p1_req = 1'b0;
    tick();

    // p0 write then read-back.
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'h1001_0008; p0_wdata = 32'hDEAD_BEEF;
    tick();
    check("wr dm_w", 32'(dm_w), 32'h1);
    check("wr dm_addr", 32'(dm_addr), 32'd2);
    check("wr dm_wdata", dm_wdata, 32'hDEAD_BEEF);
    p0_req = 1'b0;
    tick();
    check("wr p0_ack", 32'(p0_ack), 32'h1);
    check("wr p0_err", 32'(p0_err), 32'h0);
    tick();
    p0_req = 1'b1; p0_we = 1'b0;
    tick();
    check("rd dm_r", 32'(dm_r), 32'h1);
    p0_req = 1'b0;
    tick();
    check("rd p0_rdata", p0_rdata, 32'hDEAD_BEEF);
    tick();

    // Illegal p1 reads: no strobe, err set, rdata preserved.
    for (int i = 0; i < 3; i++) begin
      p1_req = 1'b1; p1_we = 1'b0; p1_addr = bad_addr[i];
      tick();
      check("bad dm_r", 32'(dm_r), 32'h0);
      p1_req = 1'b0;
      tick();
      check("bad p1_ack", 32'(p1_ack), 32'h1);
      check("bad p1_err", 32'(p1_err), 32'h1);
      check("bad p1_rdata", p1_rdata, 32'hA000_0007);
      tick();
    end

    // Last legal word.
    p1_req = 1'b1; p1_addr = 32'h1001_1FFC;
    tick();
    p1_req = 1'b0;
    tick();
    check("top p1_err", 32'(p1_err), 32'h0);
    check("top p1_rdata", p1_rdata, 32'hA000_07FF);
    tick();

    // Drop req after grant, then re-request during ack: next access at N+3.
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = Base + 32'h40; p0_wdata = 32'h1234_5678;
    tick();
    p0_req = 1'b0;
    tick();
    check("drop p0_ack", 32'(p0_ack), 32'h1);
    p0_req = 1'b1; p0_we = 1'b0;
    tick();
    check("rereq idle busy", 32'(busy), 32'h0);
    tick();
    check("rereq dm_r", 32'(dm_r), 32'h1);
    check("rereq dm_addr", 32'(dm_addr), 32'd16);
    p0_req = 1'b0;
    tick();
    check("rereq p0_rdata", p0_rdata, 32'h1234_5678);
    tick();

    // Reset during ACCESS aborts the read with no ack.
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = Base + 32'd20;
    tick();
    rst = 1'b0; p0_req = 1'b0;
    tick();
    check("abort busy", 32'(busy), 32'h0);
    check("abort p0_ack", 32'(p0_ack), 32'h0);
    check("abort p0_rdata", p0_rdata, 32'h0);
    check("abort dm_r", 32'(dm_r), 32'h0);
    rst = 1'b1;
    tick();

    // Pointer back to p1 after reset: p0 wins the tie.
    p0_req = 1'b1; p0_addr = Base + 32'd36;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = Base + 32'd40;
    tick();
    check("post-rst dm_addr", 32'(dm_addr), 32'd9);
    p0_req = 1'b0; p1_req = 1'b0;
    tick();
    check("post-rst p0_ack", 32'(p0_ack), 32'h1);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
